vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Programmable VGA raster timing generator for the front-panel video path; runs on the 25 MHz pixel clock.
- Sits directly upstream of vga_blinkenlights.
- Produces the pixel coordinates used to address the font BRAM and the character/panel logic.
- Produces hs/vs/de delayed to line up with the BRAM read latency, plus line and frame strobes.

Parameters:
RES_H, 640, active pixels per line
FP_H, 16, horizontal front porch (pixels)
SYNC_H, 96, horizontal sync width (pixels)
BP_H, 48, horizontal back porch (pixels)
NEG_H, 1, 1 = hs asserted low
RES_V, 480, active lines per frame
FP_V, 10, vertical front porch (lines)
SYNC_V, 2, vertical sync width (lines)
BP_V, 33, vertical back porch (lines)
NEG_V, 1, 1 = vs asserted low
DELAY, 2, extra pipeline stages on hs/vs/de relative to x/y (0..7)
LEAD, 8, prefetch lead in pixels (optional feature only)

Ports:
clock  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
x  out  12  current horizontal count, 0..H_TOTAL-1
y  out  12  current vertical count, 0..V_TOTAL-1
active  out  1  x<RES_H && y<RES_V, aligned with x/y
hs  out  1  horizontal sync at NEG_H polarity, delayed DELAY cycles
vs  out  1  vertical sync at NEG_V polarity, delayed DELAY cycles
de  out  1  display enable, delayed DELAY cycles
line_start  out  1  one-cycle pulse when x==0, aligned with x/y
frame_start  out  1  one-cycle pulse when x==0 && y==0, aligned with x/y

Behaviour:
- One clock (clock). Reset is asynchronous and active-high (reset). All state is in the clock domain.
- H_TOTAL = RES_H+FP_H+SYNC_H+BP_H; V_TOTAL = RES_V+FP_V+SYNC_V+BP_V. All arithmetic is 12-bit unsigned.
- Elaboration check: H_TOTAL and V_TOTAL must each be ≤4095, else fatal error.
- Line order is active, front porch, sync, back porch. Frame order is the same.
- x and y are the registered counters themselves, so x/y/active/line_start/frame_start have zero latency from the counter state.
- Each cycle x increments. When x==H_TOTAL-1, x wraps to 0 and y increments. When y==V_TOTAL-1 at the same time, y wraps to 0.
- Raw sync/enable terms, computed from the current x/y:
  - hs_raw = x in [RES_H+FP_H, RES_H+FP_H+SYNC_H)
  - vs_raw = y in [RES_V+FP_V, RES_V+FP_V+SYNC_V), whole lines, changing at x==0
  - de_raw = active
- hs_raw, vs_raw and de_raw are registered once, then pass through DELAY further stages. Total latency from x/y is DELAY+1 cycles.
- Polarity is applied at the output stage: asserted level is 0 if NEG_x, else 1.
- Reset values:
  - x=0, y=0
  - every pipeline stage cleared to deasserted
  - hs = NEG_H, vs = NEG_V, de = 0
  - line_start = 0, frame_start = 0 (combinational from x/y is not allowed; both are registered with x/y, so they read 0 in reset and 1 in the first cycle after release)
- The first cycle after reset release is x=0, y=0 with line_start=1 and frame_start=1.
- Reset mid-frame clears the counters and the whole pipeline immediately. No partial sync pulse remains asserted.
- DELAY=0: a single register stage.

Optional Feature:
- Macro: VGA_TIMING_PREFETCH_EN.
- When defined, adds ports fetch_x (12 bits) and fetch_y (12 bits) plus fetch_active.
- fetch_x/fetch_y equal the position LEAD pixels ahead of x/y, wrapping across line and frame boundaries. At x=H_TOTAL-LEAD the outputs are fetch_x=0 and fetch_y=(y+1) mod V_TOTAL.
- fetch_active is the active flag for the fetch position.
- These outputs are implemented as a second counter pair reset to (LEAD, 0), not by adding.
- When the macro is undefined, these ports and the logic do not exist.

Decomposition:
- Shared package vga_pkg holds:
  - a timing struct (res/fp/sync/bp/neg per axis)
  - preset constants VGA_640x480, VGA_720x400, VGA_720x480
  - the functions h_total()/v_total()
- One sub-module, vga_axis_counter: a wrap counter with a carry-in enable and a carry-out. It is instantiated twice (horizontal; vertical enabled by the horizontal carry) and twice more under the prefetch macro.

Test Plan:
- Reset release, defaults: first cycle x=0, y=0, frame_start=1. hs goes low for cycles with x=656..751, i.e. outputs low 96 cycles starting 3 cycles after x reaches 656 (DELAY=2).
- Full frame: frame_start pulses exactly every 420000 cycles. line_start pulses every 800 cycles, 525 per frame.
- vs low exactly on lines 490–491 (1600 cycles). de high 640 cycles per line on lines 0–479 only, 307200 per frame.
- Assert reset at x=700, y=491 (inside both syncs): on the same edge hs=1, vs=1, de=0, x=0, y=0. Pipeline does not glitch after release.
- NEG_H=0, NEG_V=0, DELAY=0: hs high at 1-cycle latency for x=656..751. Idle level 0 during reset.
- With VGA_TIMING_PREFETCH_EN, LEAD=8: at x=792, y=524 the outputs are fetch_x=0, fetch_y=0. fetch_x−x ≡ 8 (mod 800) holds every cycle.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg: timing struct, standard mode presets and line/frame totals.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package vga_pkg;

  typedef struct packed {
    logic [11:0] res;
    logic [11:0] fp;
    logic [11:0] sync;
    logic [11:0] bp;
    logic        neg;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480 = '{
    h: '{res: 12'd640, fp: 12'd16, sync: 12'd96,  bp: 12'd48, neg: 1'b1},
    v: '{res: 12'd480, fp: 12'd10, sync: 12'd2,   bp: 12'd33, neg: 1'b1}
  };

  localparam vga_timing_t VGA_720x400 = '{
    h: '{res: 12'd720, fp: 12'd18, sync: 12'd108, bp: 12'd54, neg: 1'b1},
    v: '{res: 12'd400, fp: 12'd12, sync: 12'd2,   bp: 12'd35, neg: 1'b0}
  };

  localparam vga_timing_t VGA_720x480 = '{
    h: '{res: 12'd720, fp: 12'd16, sync: 12'd62,  bp: 12'd60, neg: 1'b1},
    v: '{res: 12'd480, fp: 12'd9,  sync: 12'd6,   bp: 12'd30, neg: 1'b1}
  };

  // One bit wider than the counters so an oversized mode is visible to callers.
  function automatic logic [12:0] axis_total(input vga_axis_t a);
    return 13'(a.res) + 13'(a.fp) + 13'(a.sync) + 13'(a.bp);
  endfunction

  function automatic logic [12:0] h_total(input vga_timing_t t);
    return axis_total(t.h);
  endfunction

  function automatic logic [12:0] v_total(input vga_timing_t t);
    return axis_total(t.v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_axis_counter: 12-bit wrap counter with carry-in enable and carry-out. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_axis_counter #(
  parameter int unsigned TOTAL   = 800,
  parameter int unsigned RST_VAL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [11:0] o_count,
  output logic [11:0] o_count_nxt,
  output logic        o_carry
);

  localparam logic [11:0] c_last    = 12'(TOTAL - 1);
  localparam logic [11:0] c_rst_val = 12'(RST_VAL);

  logic [11:0] r_count;

  always_comb begin
    o_carry     = i_en && (r_count == c_last);
    o_count_nxt = r_count;
    if (o_carry) begin
      o_count_nxt = '0;
    end else if (i_en) begin
      o_count_nxt = r_count + 12'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= c_rst_val;
    end else begin
      r_count <= o_count_nxt;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing: programmable VGA raster generator with delayed hs/vs/de.      |
// | Optional lead-ahead fetch counters under VGA_TIMING_PREFETCH_EN.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned RES_H  = 640,
  parameter int unsigned FP_H   = 16,
  parameter int unsigned SYNC_H = 96,
  parameter int unsigned BP_H   = 48,
  parameter int unsigned NEG_H  = 1,
  parameter int unsigned RES_V  = 480,
  parameter int unsigned FP_V   = 10,
  parameter int unsigned SYNC_V = 2,
  parameter int unsigned BP_V   = 33,
  parameter int unsigned NEG_V  = 1,
  parameter int unsigned DELAY  = 2,
  parameter int unsigned LEAD   = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        active,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        line_start,
`ifdef VGA_TIMING_PREFETCH_EN
  output logic        frame_start,
  output logic [11:0] fetch_x,
  output logic [11:0] fetch_y,
  output logic        fetch_active
`else
  output logic        frame_start
`endif
);

  localparam vga_timing_t c_cfg = '{
    h: '{res: 12'(RES_H), fp: 12'(FP_H), sync: 12'(SYNC_H), bp: 12'(BP_H), neg: (NEG_H != 0)},
    v: '{res: 12'(RES_V), fp: 12'(FP_V), sync: 12'(SYNC_V), bp: 12'(BP_V), neg: (NEG_V != 0)}
  };
  localparam logic [11:0] c_h_total  = 12'(h_total(c_cfg));
  localparam logic [11:0] c_v_total  = 12'(v_total(c_cfg));
  localparam logic [11:0] c_hs_start = c_cfg.h.res + c_cfg.h.fp;
  localparam logic [11:0] c_hs_end   = c_hs_start + c_cfg.h.sync;
  localparam logic [11:0] c_vs_start = c_cfg.v.res + c_cfg.v.fp;
  localparam logic [11:0] c_vs_end   = c_vs_start + c_cfg.v.sync;

  if (RES_H + FP_H + SYNC_H + BP_H > 4095) begin : g_h_total_check
    $fatal(1, "vga_timing: H_TOTAL exceeds 4095");
  end
  if (RES_V + FP_V + SYNC_V + BP_V > 4095) begin : g_v_total_check
    $fatal(1, "vga_timing: V_TOTAL exceeds 4095");
  end
  if (DELAY > 7) begin : g_delay_check
    $fatal(1, "vga_timing: DELAY must be 0..7");
  end
  if (LEAD >= RES_H + FP_H + SYNC_H + BP_H) begin : g_lead_check
    $fatal(1, "vga_timing: LEAD must be below H_TOTAL");
  end

  // Counters hold for the first edge after reset so that cycle shows x=0,y=0 with both strobes.
  logic        r_run;
  logic [11:0] w_x, w_x_nxt, w_y, w_y_nxt;
  logic        w_h_carry, w_v_carry;
  logic        r_active, r_line_start, r_frame_start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  vga_axis_counter #(.TOTAL(c_h_total), .RST_VAL(0)) u_h_cnt (
    .clk(clock), .rst(reset), .i_en(r_run),
    .o_count(w_x), .o_count_nxt(w_x_nxt), .o_carry(w_h_carry)
  );

  vga_axis_counter #(.TOTAL(c_v_total), .RST_VAL(0)) u_v_cnt (
    .clk(clock), .rst(reset), .i_en(w_h_carry),
    .o_count(w_y), .o_count_nxt(w_y_nxt), .o_carry(w_v_carry)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_active      <= (w_x_nxt < c_cfg.h.res) && (w_y_nxt < c_cfg.v.res);
      r_line_start  <= w_h_carry || !r_run;
      r_frame_start <= w_v_carry || !r_run;
    end
  end

  // Pipeline carries asserted-high {hs, vs, de}; polarity is applied only at the output.
  logic       w_hs_raw, w_vs_raw;
  logic [2:0] r_pipe [DELAY+1];

  assign w_hs_raw = (w_x >= c_hs_start) && (w_x < c_hs_end);
  assign w_vs_raw = (w_y >= c_vs_start) && (w_y < c_vs_end);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= int'(DELAY); i++) r_pipe[i] <= 3'b000;
    end else begin
      r_pipe[0] <= {w_hs_raw, w_vs_raw, r_active};
      for (int i = 1; i <= int'(DELAY); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign x           = w_x;
  assign y           = w_y;
  assign active      = r_active;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign hs          = r_pipe[DELAY][2] ^ c_cfg.h.neg;
  assign vs          = r_pipe[DELAY][1] ^ c_cfg.v.neg;
  assign de          = r_pipe[DELAY][0];

`ifdef VGA_TIMING_PREFETCH_EN
  logic [11:0] w_fx, w_fx_nxt, w_fy, w_fy_nxt;
  logic        w_fh_carry, w_fv_carry_unused;
  logic        r_fetch_active;

  vga_axis_counter #(.TOTAL(c_h_total), .RST_VAL(LEAD)) u_fh_cnt (
    .clk(clock), .rst(reset), .i_en(r_run),
    .o_count(w_fx), .o_count_nxt(w_fx_nxt), .o_carry(w_fh_carry)
  );

  vga_axis_counter #(.TOTAL(c_v_total), .RST_VAL(0)) u_fv_cnt (
    .clk(clock), .rst(reset), .i_en(w_fh_carry),
    .o_count(w_fy), .o_count_nxt(w_fy_nxt), .o_carry(w_fv_carry_unused)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_active <= 1'b0;
    end else begin
      r_fetch_active <= (w_fx_nxt < c_cfg.h.res) && (w_fy_nxt < c_cfg.v.res);
    end
  end

  assign fetch_x      = w_fx;
  assign fetch_y      = w_fy;
  assign fetch_active = r_fetch_active;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_timing: scoreboard bench for a small-raster and a default-raster DUT.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_vga_timing;

  localparam int A_RH = 16, A_FH = 2, A_SH = 3, A_BH = 4, A_HT = 25;
  localparam int A_RV = 6,  A_FV = 2, A_SV = 1, A_BV = 2, A_VT = 11;
  localparam int A_D  = 2,  A_LEAD = 3;
  localparam int B_RH = 640, B_RV = 480, B_HT = 800, B_VT = 525, B_D = 0, B_LEAD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] a_x, a_y, b_x, b_y;
  logic a_active, a_hs, a_vs, a_de, a_ls, a_fs;
  logic b_active, b_hs, b_vs, b_de, b_ls, b_fs;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [11:0] a_fx, a_fy, b_fx, b_fy;
  logic a_fa, b_fa;
`endif

  vga_timing #(
    .RES_H(A_RH), .FP_H(A_FH), .SYNC_H(A_SH), .BP_H(A_BH), .NEG_H(1),
    .RES_V(A_RV), .FP_V(A_FV), .SYNC_V(A_SV), .BP_V(A_BV), .NEG_V(1),
    .DELAY(A_D), .LEAD(A_LEAD)
  ) u_dut_a (
    .clock(clk), .reset(rst), .x(a_x), .y(a_y), .active(a_active),
    .hs(a_hs), .vs(a_vs), .de(a_de), .line_start(a_ls),
`ifdef VGA_TIMING_PREFETCH_EN
    .frame_start(a_fs), .fetch_x(a_fx), .fetch_y(a_fy), .fetch_active(a_fa)
`else
    .frame_start(a_fs)
`endif
  );

  vga_timing #(.NEG_H(0), .NEG_V(0), .DELAY(B_D), .LEAD(B_LEAD)) u_dut_b (
    .clock(clk), .reset(rst), .x(b_x), .y(b_y), .active(b_active),
    .hs(b_hs), .vs(b_vs), .de(b_de), .line_start(b_ls),
`ifdef VGA_TIMING_PREFETCH_EN
    .frame_start(b_fs), .fetch_x(b_fx), .fetch_y(b_fy), .fetch_active(b_fa)
`else
    .frame_start(b_fs)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] qa[$];
  logic [2:0] qb[$];
  int ax, ay, bx, by, cyc, last_fs;
  bit run;
  int a_fs_cnt, a_ls_cnt, a_de_cnt, a_vs_cnt, a_hs_cnt, b_hs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv(inout int px, inout int py, input int ht, input int vt);
    if (px == ht - 1) begin
      px = 0;
      py = (py == vt - 1) ? 0 : py + 1;
    end else begin
      px++;
    end
  endtask

  task automatic fetch_pos(input int px, input int py, input int lead, input int ht,
                           input int vt, output int fx, output int fy);
    fx = px + lead;
    fy = py;
    if (fx >= ht) begin
      fx -= ht;
      fy = (fy + 1) % vt;
    end
  endtask

  task automatic clear_stats();
    a_fs_cnt = 0; a_ls_cnt = 0; a_de_cnt = 0; a_vs_cnt = 0; a_hs_cnt = 0; b_hs_cnt = 0;
  endtask

  // One pixel clock: advance the model, compare counters/strobes, pop the delayed sync expectation.
  task automatic tick();
    logic [2:0] e;
    logic       a_act_exp, b_act_exp;
    int         fx, fy;
    @(posedge clk);
    if (run) begin
      adv(ax, ay, A_HT, A_VT);
      adv(bx, by, B_HT, B_VT);
    end
    run = 1'b1;
    cyc++;
    @(negedge clk);
    a_act_exp = (ax < A_RH) && (ay < A_RV);
    b_act_exp = (bx < B_RH) && (by < B_RV);
    chk("a_x", a_x, ax);
    chk("a_y", a_y, ay);
    chk("a_active", a_active, a_act_exp);
    chk("a_line_start", a_ls, ax == 0);
    chk("a_frame_start", a_fs, (ax == 0) && (ay == 0));
    e = qa.pop_front();
    chk("a_hs", a_hs, !e[2]);
    chk("a_vs", a_vs, !e[1]);
    chk("a_de", a_de, e[0]);
    qa.push_back({(ax >= A_RH + A_FH) && (ax < A_RH + A_FH + A_SH),
                  (ay >= A_RV + A_FV) && (ay < A_RV + A_FV + A_SV), a_act_exp});
    chk("b_x", b_x, bx);
    chk("b_y", b_y, by);
    chk("b_line_start", b_ls, bx == 0);
    chk("b_frame_start", b_fs, (bx == 0) && (by == 0));
    e = qb.pop_front();
    chk("b_hs", b_hs, e[2]);
    chk("b_vs", b_vs, e[1]);
    chk("b_de", b_de, e[0]);
    qb.push_back({(bx >= 656) && (bx < 752), (by >= 490) && (by < 492), b_act_exp});
`ifdef VGA_TIMING_PREFETCH_EN
    fetch_pos(ax, ay, A_LEAD, A_HT, A_VT, fx, fy);
    chk("a_fetch_x", a_fx, fx);
    chk("a_fetch_y", a_fy, fy);
    chk("a_fetch_active", a_fa, (fx < A_RH) && (fy < A_RV));
    fetch_pos(bx, by, B_LEAD, B_HT, B_VT, fx, fy);
    chk("b_fetch_x", b_fx, fx);
    chk("b_fetch_y", b_fy, fy);
`else
    fx = 0;
    fy = 0;
`endif
    if (a_fs) begin
      if (last_fs >= 0) chk("a_frame_period", cyc - last_fs, A_HT * A_VT);
      last_fs = cyc;
    end
    a_fs_cnt += int'(a_fs);
    a_ls_cnt += int'(a_ls);
    a_de_cnt += int'(a_de);
    a_vs_cnt += int'(!a_vs);
    a_hs_cnt += int'(!a_hs);
    b_hs_cnt += int'(b_hs);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ax = 0; ay = 0; bx = 0; by = 0;
    run = 1'b0;
    last_fs = -1;
    qa.delete();
    qb.delete();
    for (int i = 0; i <= A_D; i++) qa.push_back(3'b000);
    for (int i = 0; i <= B_D; i++) qb.push_back(3'b000);
    repeat (2) @(negedge clk);
    chk("rst_a_x", a_x, 0);
    chk("rst_a_y", a_y, 0);
    chk("rst_a_line_start", a_ls, 0);
    chk("rst_a_frame_start", a_fs, 0);
    chk("rst_a_active", a_active, 0);
    chk("rst_a_hs", a_hs, 1);
    chk("rst_a_vs", a_vs, 1);
    chk("rst_a_de", a_de, 0);
    chk("rst_b_hs", b_hs, 0);
    chk("rst_b_vs", b_vs, 0);
    chk("rst_b_de", b_de, 0);
`ifdef VGA_TIMING_PREFETCH_EN
    chk("rst_a_fetch_x", a_fx, A_LEAD);
    chk("rst_a_fetch_y", a_fy, 0);
    chk("rst_a_fetch_active", a_fa, 0);
`endif
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    cyc = 0;
    #2;
    do_reset();

    // Exactly one frame of the small raster, starting on its first cycle.
    clear_stats();
    for (int i = 0; i < A_HT * A_VT; i++) tick();
    chk("a_frames_per_frame", a_fs_cnt, 1);
    chk("a_lines_per_frame", a_ls_cnt, A_VT);
    chk("a_de_per_frame", a_de_cnt, A_RH * A_RV);
    chk("a_vs_low_per_frame", a_vs_cnt, A_HT * A_SV);
    chk("a_hs_low_per_frame", a_hs_cnt, A_SH * A_VT);

    // Keep going to one full default line for the positive-polarity, zero-delay DUT.
    for (int i = A_HT * A_VT; i < B_HT; i++) tick();
    chk("b_hs_high_first_line", b_hs_cnt, 96);

    // Land inside both output sync pulses of the small raster, then reset mid-cycle.
    found = 1'b0;
    for (int i = 0; i < 2 * A_HT * A_VT && !found; i++) begin
      tick();
      if (ax == A_HT - 2 && ay == A_RV + A_FV) found = 1'b1;
    end
    chk("reach_mid_sync", found, 1);
    chk("pre_rst_a_hs", a_hs, 0);
    chk("pre_rst_a_vs", a_vs, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_a_hs", a_hs, 1);
    chk("async_a_vs", a_vs, 1);
    chk("async_a_de", a_de, 0);
    chk("async_a_x", a_x, 0);
    chk("async_a_y", a_y, 0);
    chk("async_b_hs", b_hs, 0);
    do_reset();

    clear_stats();
    for (int i = 0; i < A_HT * A_VT + 40; i++) tick();
    chk("a_frames_after_rst", a_fs_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
